// File: rtl/alu16_sequencer.sv
// 16-bit ADD/SUB/INC/DEC sequencer driving an external 8-bit combinational ALU over low, high and carry fix-up passes.
// Optional macro ALU16_SEQ_PERF_EN adds perf_ops/perf_fix completion and fix-up counters.
module alu16_sequencer #(
  parameter int                  ALU_OP_W = 5,
  parameter logic [ALU_OP_W-1:0] OP_ADD   = 5'b00000,
  parameter logic [ALU_OP_W-1:0] OP_SUB   = 5'b00001,
  parameter logic [ALU_OP_W-1:0] OP_INC   = 5'b01100,
  parameter logic [ALU_OP_W-1:0] OP_DEC   = 5'b01101
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic [1:0]          req_op,
  input  logic [15:0]         req_a,
  input  logic [15:0]         req_b,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [15:0]         rsp_result,
  output logic [7:0]          rsp_flags,
  output logic [7:0]          alu_a,
  output logic [7:0]          alu_b,
  output logic [ALU_OP_W-1:0] alu_opcode,
  input  logic [7:0]          alu_out,
  input  logic [7:0]          alu_flags
`ifdef ALU16_SEQ_PERF_EN
  ,
  output logic [15:0]         perf_ops,
  output logic [15:0]         perf_fix
`endif
);

  typedef enum logic [2:0] {IDLE, LO, HI, FIX, DONE} state_t;

  state_t      state, state_d;
  logic        sub_q;
  logic [15:0] a_q, b_q;
  logic [7:0]  res_lo, res_hi;
  logic        c_lo, c_hi, h_hi, pv_hi, c_fix;
  logic        ready_q;
  logic        accept;

  // Only C, PV and H from the ALU matter; the remaining flag bits are deliberately dropped.
  logic unused_alu_flags;
  assign unused_alu_flags = ^{alu_flags[7:5], alu_flags[3], alu_flags[1]};

  assign accept     = (state == IDLE) && ready_q && req_valid;
  assign req_ready  = ready_q;
  assign rsp_valid  = (state == DONE);
  assign rsp_result = {res_hi, res_lo};
  assign rsp_flags  = {res_hi[7], (rsp_result == 16'h0000), 1'b0, h_hi,
                       1'b0, pv_hi, sub_q, c_hi | c_fix};

  // NOTE: every output of this block gets a default first, so no path can infer a latch.
  always_comb begin
    state_d    = state;
    alu_a      = 8'h00;
    alu_b      = 8'h00;
    alu_opcode = OP_ADD;
    unique case (state)
      IDLE: if (accept) state_d = LO;
      LO: begin
        alu_a      = a_q[7:0];
        alu_b      = b_q[7:0];
        alu_opcode = sub_q ? OP_SUB : OP_ADD;
        state_d    = HI;
      end
      HI: begin
        alu_a      = a_q[15:8];
        alu_b      = b_q[15:8];
        alu_opcode = sub_q ? OP_SUB : OP_ADD;
        state_d    = c_lo ? FIX : DONE;
      end
      FIX: begin
        // The 8-bit ALU has no carry-in, so the low-byte carry/borrow is folded in here.
        alu_a      = res_hi;
        alu_opcode = sub_q ? OP_DEC : OP_INC;
        state_d    = DONE;
      end
      DONE: if (rsp_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= IDLE;
      ready_q <= 1'b0;
      sub_q   <= 1'b0;
      a_q     <= 16'h0000;
      b_q     <= 16'h0000;
      res_lo  <= 8'h00;
      res_hi  <= 8'h00;
      c_lo    <= 1'b0;
      c_hi    <= 1'b0;
      h_hi    <= 1'b0;
      pv_hi   <= 1'b0;
      c_fix   <= 1'b0;
    end else begin
      state   <= state_d;
      ready_q <= (state_d == IDLE);
      unique case (state)
        IDLE: if (accept) begin
          sub_q <= req_op[0];
          a_q   <= req_a;
          b_q   <= req_op[1] ? 16'h0001 : req_b;
          c_fix <= 1'b0;
        end
        LO: begin
          res_lo <= alu_out;
          c_lo   <= alu_flags[0];
        end
        HI: begin
          res_hi <= alu_out;
          c_hi   <= alu_flags[0];
          h_hi   <= alu_flags[4];
          pv_hi  <= alu_flags[2];
        end
        FIX: begin
          res_hi <= alu_out;
          // Carry out of the fix-up is judged from the wrapped value, not from alu_flags.
          c_fix  <= sub_q ? (alu_out == 8'hFF) : (alu_out == 8'h00);
        end
        default: ;
      endcase
    end
  end

`ifdef ALU16_SEQ_PERF_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_ops <= 16'h0000;
      perf_fix <= 16'h0000;
    end else begin
      if (rsp_valid && rsp_ready) perf_ops <= perf_ops + 16'h0001;
      if (state == FIX)           perf_fix <= perf_fix + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_alu16_sequencer.sv
// Self-checking bench for alu16_sequencer: models the 8-bit ALU and predicts 16-bit results with integer arithmetic.
module tb_alu16_sequencer;

  localparam logic [4:0] OP_ADD = 5'b00000;
  localparam logic [4:0] OP_SUB = 5'b00001;
  localparam logic [4:0] OP_INC = 5'b01100;
  localparam logic [4:0] OP_DEC = 5'b01101;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic [1:0]  req_op = 2'b00;
  logic [15:0] req_a = 16'h0000;
  logic [15:0] req_b = 16'h0000;
  logic        rsp_valid;
  logic        rsp_ready = 1'b0;
  logic [15:0] rsp_result;
  logic [7:0]  rsp_flags;
  logic [7:0]  alu_a, alu_b, alu_out, alu_flags;
  logic [4:0]  alu_opcode;
`ifdef ALU16_SEQ_PERF_EN
  logic [15:0] perf_ops, perf_fix;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  alu16_sequencer dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_op     (req_op),
    .req_a      (req_a),
    .req_b      (req_b),
    .rsp_valid  (rsp_valid),
    .rsp_ready  (rsp_ready),
    .rsp_result (rsp_result),
    .rsp_flags  (rsp_flags),
    .alu_a      (alu_a),
    .alu_b      (alu_b),
    .alu_opcode (alu_opcode),
    .alu_out    (alu_out),
    .alu_flags  (alu_flags)
`ifdef ALU16_SEQ_PERF_EN
    ,
    .perf_ops   (perf_ops),
    .perf_fix   (perf_fix)
`endif
  );

  always #5 clk = ~clk;

  // 8-bit ALU: returns {flags, out}; INC/DEC leave C at 0 so the sequencer must not trust it in fix-up.
  function automatic logic [15:0] alu_model(input logic [7:0] a, input logic [7:0] b, input logic [4:0] opc);
    logic [8:0] s;
    logic       h, pv;
    logic [7:0] fl;
    fl = 8'h00;
    s  = {1'b0, 8'hA5};
    h  = 1'b0;
    pv = 1'b0;
    if (opc == OP_ADD) begin
      s  = {1'b0, a} + {1'b0, b};
      h  = ({1'b0, a[3:0]} + {1'b0, b[3:0]}) > 5'd15;
      pv = (a[7] == b[7]) && (s[7] != a[7]);
    end else if (opc == OP_SUB) begin
      s  = {1'b0, a} - {1'b0, b};
      h  = a[3:0] < b[3:0];
      pv = (a[7] != b[7]) && (s[7] != a[7]);
      fl[1] = 1'b1;
    end else if (opc == OP_INC) begin
      s = {1'b0, a + 8'h01};
    end else if (opc == OP_DEC) begin
      s = {1'b0, a - 8'h01};
      fl[1] = 1'b1;
    end
    fl[7] = s[7];
    fl[6] = (s[7:0] == 8'h00);
    fl[4] = h;
    fl[2] = pv;
    fl[0] = s[8];
    return {fl, s[7:0]};
  endfunction

  always_comb {alu_flags, alu_out} = alu_model(alu_a, alu_b, alu_opcode);

  typedef struct packed {
    logic [15:0] res;
    logic [7:0]  flags;
    logic        fix;
  } exp_t;

  // Whole-word reference: 16-bit arithmetic, with H/PV taken from the high-byte pass alone.
  function automatic exp_t ref_model(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    int ai, bi, full, sa, sb, sv;
    logic [15:0] bb;
    logic c, h, pv;
    ai = int'(a);
    bi = op[1] ? 1 : int'(b);
    bb = 16'(bi);
    sa = int'($signed(a[15:8]));
    sb = int'($signed(bb[15:8]));
    if (!op[0]) begin
      full  = ai + bi;
      c     = full > 65535;
      h     = (((ai >> 8) & 15) + ((bi >> 8) & 15)) > 15;
      e.fix = ((ai & 255) + (bi & 255)) > 255;
      sv    = sa + sb;
    end else begin
      full  = ai - bi;
      c     = ai < bi;
      h     = ((ai >> 8) & 15) < ((bi >> 8) & 15);
      e.fix = (ai & 255) < (bi & 255);
      sv    = sa - sb;
    end
    pv      = (sv > 127) || (sv < -128);
    e.res   = 16'(full);
    e.flags = {e.res[15], e.res == 16'h0000, 1'b0, h, 1'b0, pv, op[0], c};
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
    end
  endtask

  // Called at a negedge; returns at a negedge after the response handshake.
  task automatic run_op(input logic [1:0] op, input logic [15:0] a, input logic [15:0] b,
                        input int stall, input int exp_wait);
    exp_t        e;
    int          n;
    logic        fix_seen;
    logic [15:0] bb;
    e  = ref_model(op, a, b);
    bb = op[1] ? 16'h0001 : b;
    req_op = op; req_a = a; req_b = b; req_valid = 1'b1; rsp_ready = 1'b0;
    n = 0;
    while (!req_ready && n < 16) begin @(negedge clk); n++; end
    check("accept_timeout", 32'(req_ready), 32'd1);
    if (exp_wait >= 0) check("accept_wait", 32'(n), 32'(exp_wait));
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0; req_a = 16'($urandom); req_b = 16'($urandom);
    check("lo_alu_a", 32'(alu_a), 32'(a[7:0]));
    check("lo_alu_b", 32'(alu_b), 32'(bb[7:0]));
    check("lo_opcode", 32'(alu_opcode), 32'(op[0] ? OP_SUB : OP_ADD));
    n = 1; fix_seen = 1'b0;
    while (!rsp_valid && n < 12) begin
      @(negedge clk);
      n++;
      if (alu_opcode == (op[0] ? OP_DEC : OP_INC)) fix_seen = 1'b1;
    end
    check("latency", 32'(n), e.fix ? 32'd4 : 32'd3);
    check("fix_pass", 32'(fix_seen), 32'(e.fix));
    for (int i = 0; i < stall; i++) begin
      check("stall_result", 32'(rsp_result), 32'(e.res));
      check("stall_flags", 32'(rsp_flags), 32'(e.flags));
      check("stall_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
    end
    rsp_ready = 1'b1;
    check("rsp_valid", 32'(rsp_valid), 32'd1);
    check("result", 32'(rsp_result), 32'(e.res));
    check("flags", 32'(rsp_flags), 32'(e.flags));
    check("done_alu_idle", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
    @(posedge clk);
    @(negedge clk);
    rsp_ready = 1'b0;
    check("post_valid", 32'(rsp_valid), 32'd0);
    check("post_ready", 32'(req_ready), 32'd1);
  endtask

  function automatic logic [15:0] pick();
    logic [15:0] r;
    r = 16'($urandom);
    unique case ($urandom_range(0, 4))
      0: return 16'h0000;
      1: return 16'hFFFF;
      2: return {r[15:8], 8'hFF};
      3: return {r[15:8], 8'h00};
      default: return r;
    endcase
  endfunction

  initial begin
    repeat (3) @(negedge clk);
    check("rst_ready", 32'(req_ready), 32'd0);
    check("rst_valid", 32'(rsp_valid), 32'd0);
    check("rst_result", 32'(rsp_result), 32'd0);
    check("rst_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
    rst_n = 1'b1;
    @(negedge clk);
    check("ready_after_release", 32'(req_ready), 32'd1);

    run_op(2'b00, 16'h1234, 16'h0101, 0, 0);   // no fix-up
    run_op(2'b00, 16'h12FF, 16'h0001, 0, 0);   // fix-up, C=0
    run_op(2'b10, 16'hFFFF, 16'h5A5A, 0, 0);   // INC wraps, C from fix-up
    run_op(2'b01, 16'h0000, 16'h0001, 0, 0);   // SUB borrow through fix-up
    run_op(2'b11, 16'h1000, 16'hA5A5, 0, 0);   // DEC with fix-up, C=0
    run_op(2'b00, 16'h7F00, 16'h0100, 0, 0);   // high-byte signed overflow
    run_op(2'b00, 16'h0800, 16'h0800, 5, 0);   // backpressure, half carry
    run_op(2'b01, 16'h8000, 16'h0001, 0, 0);   // accepted the cycle after handshake

    // Reset during HI abandons the op immediately.
    req_op = 2'b01; req_a = 16'h5678; req_b = 16'h1234; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    @(negedge clk);
    check("hi_alu_a", 32'(alu_a), 32'h56);
    check("hi_alu_b", 32'(alu_b), 32'h12);
    check("hi_opcode", 32'(alu_opcode), 32'(OP_SUB));
    #2 rst_n = 1'b0;
    #1;
    check("rst_hi_alu", 32'({alu_a, alu_b, alu_opcode}), 32'd0);
    check("rst_hi_valid", 32'(rsp_valid), 32'd0);
    check("rst_hi_ready", 32'(req_ready), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("no_orphan_rsp", 32'(rsp_valid), 32'd0);
    end
    run_op(2'b00, 16'h0001, 16'h0001, 0, 0);

    // Reset while a response is pending drops rsp_valid without an edge.
    req_op = 2'b00; req_a = 16'h0010; req_b = 16'h0020; req_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    req_valid = 1'b0;
    repeat (2) @(negedge clk);
    check("done_before_rst", 32'(rsp_valid), 32'd1);
    #2 rst_n = 1'b0;
    #1;
    check("rst_done_valid", 32'(rsp_valid), 32'd0);
    check("rst_done_result", 32'(rsp_result), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    for (int k = 0; k < 40; k++)
      run_op(2'($urandom), pick(), pick(), int'($urandom_range(0, 3)), -1);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/alu16_sequencer.md
Name: alu16_sequencer

Overview:
- Multi-cycle controller that executes 16-bit ADD/SUB/INC/DEC by sequencing the existing 8-bit combinational ALU over two or three passes.
- Passes: low byte, high byte, then a conditional carry/borrow fix-up on the high byte. The 8-bit ALU has no carry-in, so the fix-up applies the low-byte carry or borrow.
- Sits between the decode/execute unit (valid/ready request and response) and a single 8-bit ALU instance, whose ports it drives directly.

Parameters:
- ALU_OP_W, 5, width of the ALU opcode bus.
- OP_ADD, 5'b00000, ALU add opcode.
- OP_SUB, 5'b00001, ALU subtract opcode.
- OP_INC, 5'b01100, ALU increment opcode.
- OP_DEC, 5'b01101, ALU decrement opcode.

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  sequencer can accept a request.
- req_op  in  2  00 ADD16, 01 SUB16, 10 INC16, 11 DEC16.
- req_a  in  16  first operand.
- req_b  in  16  second operand; ignored for INC16/DEC16.
- rsp_valid  out  1  result available.
- rsp_ready  in  1  consumer takes the result.
- rsp_result  out  16  16-bit result.
- rsp_flags  out  8  S Z 0 H 0 PV N C, bit 7 down to bit 0.
- alu_a  out  8  ALU operand a.
- alu_b  out  8  ALU operand b.
- alu_opcode  out  ALU_OP_W  ALU opcode.
- alu_out  in  8  ALU result, combinational from alu_a/alu_b/alu_opcode.
- alu_flags  in  8  ALU status flags; bit 0 = C, bit 4 = H, bit 2 = PV.

Behaviour:
- Reset: single clock clk; reset is asynchronous and active-low via rst_n.
  - While rst_n=0: state IDLE, all registered outputs 0, req_ready=0.
  - req_ready=1 from the first clock edge after reset release.
  - Reset mid-operation abandons the op: rsp_valid drops immediately and no response is ever produced for it.
- Operation mapping:
  - INC16 is executed as ADD16 with b=16'h0001.
  - DEC16 is executed as SUB16 with b=16'h0001.
  - Internally each op is therefore an ADD-class or SUB-class op.
- States: IDLE, LO, HI, FIX, DONE.
- IDLE:
  - req_ready=1.
  - On req_valid=1: latch op, a, b and go to LO.
- LO:
  - Drive alu_a=a[7:0], alu_b=b[7:0], opcode OP_ADD or OP_SUB.
  - At the edge: latch res_lo=alu_out and c_lo=alu_flags[0]. Go to HI.
- HI:
  - Drive alu_a=a[15:8], alu_b=b[15:8], same opcode.
  - At the edge: latch res_hi=alu_out, c_hi=alu_flags[0], h_hi=alu_flags[4], pv_hi=alu_flags[2].
  - Go to FIX if c_lo=1, else DONE.
- FIX:
  - Drive alu_a=res_hi, alu_b=0, opcode OP_INC (ADD-class) or OP_DEC (SUB-class).
  - At the edge: res_hi=alu_out; go to DONE.
  - c_fix=1 when alu_out==8'h00 (ADD-class) or alu_out==8'hFF (SUB-class).
  - c_fix is derived from the result value; alu_flags is ignored in FIX.
- DONE:
  - rsp_valid=1; rsp_result={res_hi,res_lo}.
  - rsp_result and rsp_flags hold stable until rsp_valid & rsp_ready, then go to IDLE.
  - req_ready=0 throughout DONE; a new request is accepted no earlier than the cycle after the response handshake.
- Flags:
  - S=result[15].
  - Z=(result==16'h0000).
  - H=h_hi.
  - PV=pv_hi.
  - N=1 for SUB-class, 0 for ADD-class.
  - C=c_hi | c_fix.
  - Bits 5 and 3 are 0.
- ALU drive outside LO/HI/FIX: alu_a=0, alu_b=0, alu_opcode=OP_ADD.
- Latency from the accept edge to rsp_valid=1: 3 cycles without fix-up, 4 cycles with fix-up.
- Throughput: one operation in flight at a time.

Optional Feature:
- Macro ALU16_SEQ_PERF_EN.
- Defined:
  - Adds output perf_ops[15:0]: count of completed response handshakes.
  - Adds output perf_fix[15:0]: count of FIX passes.
  - Both counters reset to 0 and wrap at 16'hFFFF -> 0.
- Undefined: the two ports and both counters are absent; all other behaviour is identical.

Test Plan:
- ADD16 a=0x1234, b=0x0101, rsp_ready=1 -> result 0x1335, flags C=0 Z=0 N=0, rsp_valid exactly 3 cycles after accept, FIX not entered.
- ADD16 a=0x12FF, b=0x0001 -> FIX entered with alu_opcode=OP_INC, result 0x1300, C=0, latency 4.
- INC16 a=0xFFFF -> result 0x0000, Z=1, C=1 (from c_fix), S=0.
- SUB16 a=0x0000, b=0x0001 -> result 0xFFFF, S=1, N=1, C=1; DEC16 a=0x1000 -> result 0x0FFF, C=0, FIX used.
- Backpressure: complete ADD16 with rsp_ready=0 for 5 cycles -> rsp_result/rsp_flags stable, req_ready=0; raise rsp_ready -> IDLE next cycle, a second request is accepted the following cycle.
- Reset: assert rst_n=0 during HI of SUB16 -> rsp_valid and ALU drive go to 0 without a clock edge; after release, ADD16 0x0001+0x0001 returns 0x0002.
